hamming_encode_s: RTL and testbench

//  Serial Hamming(7,4) transmitter; the sending end of the strobe-qualified serial decoder link.
//  - Accepts a 4-bit nibble via a start/ready handshake and computes the 7-bit codeword.
//  - Shifts the codeword out MSB-first (h[6] first, h[0] last) on d_out.
//  - Emits a one-cycle strobe_out per bit; the receiver samples d_out on the rising edge of that strobe.

---
 rtl/hamming_pkg.sv | 27 ++
 rtl/hamming74_enc.sv | 26 ++
 rtl/hamming_encode_s.sv | 161 ++++++++++++++++
 tb/tb_hamming_encode_s.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: code dimensions, bit positions and the
// transmitter FSM state encoding. Imported by the encoder and transmitter.
package hamming_pkg;

    localparam int HAM_N = 7;
    localparam int HAM_K = 4;

    // Parity bit positions inside the codeword h[6:0]
    localparam int P0_POS = 6;
    localparam int P1_POS = 5;
    localparam int P2_POS = 3;

    // Data position map, listed D3..D0: DATA_POS[0] holds D3, DATA_POS[3] holds D0
    localparam int DATA_POS [HAM_K] = '{4, 2, 1, 0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } ham_state_e;

    // Even parity of three bits
    function automatic logic parity3(input logic a, input logic b, input logic c);
        parity3 = a ^ b ^ c;
    endfunction

endpackage

// File: rtl/hamming74_enc.sv
// Combinational Hamming(7,4) encoder: 4 data bits in, 7-bit codeword out.
// Parity equations match the receiver's syndrome checks.
module hamming74_enc
    import hamming_pkg::*;
(
    input  logic [3:0] i_data,
    output logic [6:0] o_code
);

    logic [6:0] w_code;

    // Place data bits at their positions and fill in the three parity bits
    always_comb begin
        w_code                = 7'd0;
        w_code[DATA_POS[0]]   = i_data[3];
        w_code[DATA_POS[1]]   = i_data[2];
        w_code[DATA_POS[2]]   = i_data[1];
        w_code[DATA_POS[3]]   = i_data[0];
        w_code[P0_POS]        = parity3(i_data[3], i_data[2], i_data[0]);
        w_code[P1_POS]        = parity3(i_data[3], i_data[1], i_data[0]);
        w_code[P2_POS]        = parity3(i_data[2], i_data[1], i_data[0]);
    end

    assign o_code = w_code;

endmodule

// File: rtl/hamming_encode_s.sv
// Serial Hamming(7,4) transmitter. Accepts a nibble on start/ready, shifts the
// codeword out MSB first, holding each bit BIT_CYCLES clocks with a one-cycle
// strobe at cycle STROBE_POS of each bit period, then pulses done.
// Optional macro ERROR_INJECT_EN adds err_en/err_idx to flip one sent bit.
module hamming_encode_s
    import hamming_pkg::*;
#(
    parameter int BIT_CYCLES = 4,
    parameter int STROBE_POS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d_in,
    input  logic       start,
`ifdef ERROR_INJECT_EN
    input  logic       err_en,
    input  logic [2:0] err_idx,
`endif
    output logic       ready,
    output logic       busy,
    output logic       d_out,
    output logic       strobe_out,
    output logic       done,
    output logic [6:0] codeword
);

    localparam int              CYC_W      = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] STROBE_CYC = CYC_W'(STROBE_POS);

    ham_state_e       r_state;
    logic [CYC_W-1:0] r_cyc;
    logic [2:0]       r_bit_idx;
    logic [6:0]       r_sh;
    logic [6:0]       r_codeword;
    logic             r_ready;
    logic             r_busy;
    logic             r_d_out;
    logic             r_strobe;
    logic             r_done;

    ham_state_e       w_state_nxt;
    logic [CYC_W-1:0] w_cyc_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic [6:0]       w_sh_nxt;
    logic [6:0]       w_codeword_nxt;
    logic             w_d_out_nxt;
    logic             w_strobe_nxt;
    logic [6:0]       w_code;
    logic [6:0]       w_tx;

    hamming74_enc u_enc (
        .i_data (d_in),
        .o_code (w_code)
    );

`ifdef ERROR_INJECT_EN
    // Transmitted word: clean codeword with the selected bit inverted (index 7 = none)
    always_comb begin
        if (err_en && (err_idx != 3'd7)) begin
            w_tx = w_code ^ (7'd1 << err_idx);
        end else begin
            w_tx = w_code;
        end
    end
`else
    // Transmitted word is always the clean codeword
    always_comb begin
        w_tx = w_code;
    end
`endif

    // Next-state logic for the FSM, bit timer, bit index and shift register
    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_nxt      = r_cyc;
        w_bit_idx_nxt  = r_bit_idx;
        w_sh_nxt       = r_sh;
        w_codeword_nxt = r_codeword;
        case (r_state)
            ST_IDLE: begin
                if (start && r_ready) begin
                    w_state_nxt    = ST_SEND;
                    w_cyc_nxt      = {CYC_W{1'b0}};
                    w_bit_idx_nxt  = 3'd6;
                    w_sh_nxt       = w_tx;
                    w_codeword_nxt = w_code;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (r_cyc == CYC_LAST) begin
                    w_cyc_nxt = {CYC_W{1'b0}};
                    if (r_bit_idx == 3'd0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx - 3'd1;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + {{(CYC_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up exactly with the state they describe
    always_comb begin
        w_d_out_nxt  = 1'b0;
        w_strobe_nxt = 1'b0;
        if (w_state_nxt == ST_SEND) begin
            w_d_out_nxt  = w_sh_nxt[w_bit_idx_nxt];
            w_strobe_nxt = (w_cyc_nxt == STROBE_CYC);
        end else begin
            w_d_out_nxt  = 1'b0;
            w_strobe_nxt = 1'b0;
        end
    end

    // State and output registers; reset drops any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cyc      <= {CYC_W{1'b0}};
            r_bit_idx  <= 3'd0;
            r_sh       <= 7'd0;
            r_codeword <= 7'd0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_d_out    <= 1'b0;
            r_strobe   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_sh       <= w_sh_nxt;
            r_codeword <= w_codeword_nxt;
            r_ready    <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt == ST_SEND) || (w_state_nxt == ST_DONE);
            r_d_out    <= w_d_out_nxt;
            r_strobe   <= w_strobe_nxt;
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    assign ready      = r_ready;
    assign busy       = r_busy;
    assign d_out      = r_d_out;
    assign strobe_out = r_strobe;
    assign done       = r_done;
    assign codeword   = r_codeword;

endmodule

// File: tb/tb_hamming_encode_s.sv
// Bench for hamming_encode_s: cycle-level timeline model of the main instance,
// a strobe-sampling receiver with a syndrome decoder, and loopback instances
// with BIT_CYCLES=2 and BIT_CYCLES=5.
module tb_hamming_encode_s;

    localparam int BC  = 4;
    localparam int SP  = 1;
    localparam int FRM = 7 * BC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [3:0] d_in;
    logic       ready, busy, d_out, strobe_out, done;
    logic [6:0] codeword;
`ifdef ERROR_INJECT_EN
    logic       err_en;
    logic [2:0] err_idx;
`endif

    logic       start2, start5;
    logic [3:0] d_in2, d_in5;
    logic       ready2, busy2, d_out2, strobe2, done2;
    logic       ready5, busy5, d_out5, strobe5, done5;
    logic [6:0] codeword2, codeword5;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    hamming_encode_s #(.BIT_CYCLES(BC), .STROBE_POS(SP)) u_dut (
        .clk(clk), .rst(rst), .d_in(d_in), .start(start),
`ifdef ERROR_INJECT_EN
        .err_en(err_en), .err_idx(err_idx),
`endif
        .ready(ready), .busy(busy), .d_out(d_out), .strobe_out(strobe_out),
        .done(done), .codeword(codeword)
    );

    hamming_encode_s #(.BIT_CYCLES(2), .STROBE_POS(1)) u_dut2 (
        .clk(clk), .rst(rst), .d_in(d_in2), .start(start2),
`ifdef ERROR_INJECT_EN
        .err_en(1'b0), .err_idx(3'd7),
`endif
        .ready(ready2), .busy(busy2), .d_out(d_out2), .strobe_out(strobe2),
        .done(done2), .codeword(codeword2)
    );

    hamming_encode_s #(.BIT_CYCLES(5), .STROBE_POS(3)) u_dut5 (
        .clk(clk), .rst(rst), .d_in(d_in5), .start(start5),
`ifdef ERROR_INJECT_EN
        .err_en(1'b0), .err_idx(3'd7),
`endif
        .ready(ready5), .busy(busy5), .d_out(d_out5), .strobe_out(strobe5),
        .done(done5), .codeword(codeword5)
    );

    // ---------------- reference functions ----------------
    function automatic logic [2:0] syndrome(input logic [6:0] w);
        syndrome = {w[6] ^ w[4] ^ w[2] ^ w[0],
                    w[5] ^ w[4] ^ w[1] ^ w[0],
                    w[3] ^ w[2] ^ w[1] ^ w[0]};
    endfunction

    // The codeword is the unique 7-bit word carrying d at the data positions
    // and satisfying every parity check.
    function automatic logic [6:0] ref_encode(input logic [3:0] d);
        logic [6:0] w;
        ref_encode = 7'd0;
        for (int c = 0; c < 128; c++) begin
            w = 7'(c);
            if (({w[4], w[2], w[1], w[0]} == d) && (syndrome(w) == 3'd0))
                ref_encode = w;
        end
    endfunction

    function automatic logic [3:0] ref_decode(input logic [6:0] w);
        logic [6:0] f;
        f = w;
        if (syndrome(w) != 3'd0) begin
            for (int b = 0; b < 7; b++) begin
                if (syndrome(w ^ (7'd1 << b)) == 3'd0)
                    f = w ^ (7'd1 << b);
            end
        end
        ref_decode = {f[4], f[2], f[1], f[0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // ---------------- timeline model of the main instance ----------------
    logic       m_active = 1'b0;
    int         m_k      = 0;
    int         m_acc    = 0;
    logic [6:0] m_tx     = 7'd0;
    logic [6:0] m_cw     = 7'd0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_cw     <= 7'd0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_acc    <= cyc_n + 1;
                m_cw     <= ref_encode(d_in);
`ifdef ERROR_INJECT_EN
                m_tx     <= ref_encode(d_in) ^
                            ((err_en && err_idx != 3'd7) ? (7'd1 << err_idx) : 7'd0);
`else
                m_tx     <= ref_encode(d_in);
`endif
            end
        end else if (m_k == FRM + 1) begin
            m_active <= 1'b0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    // Compare process: every cycle, {ready,busy,d_out,strobe_out,done} and codeword
    always @(negedge clk) begin
        logic [4:0] exp_o;
        if (cyc_n > 0) begin
            if (!m_active)
                exp_o = 5'b10000;
            else if (m_k <= FRM)
                exp_o = {1'b0, 1'b1, m_tx[6 - (m_k - 1) / BC], ((m_k - 1) % BC) == SP, 1'b0};
            else
                exp_o = 5'b01001;
            chk("outputs", {27'd0, ready, busy, d_out, strobe_out, done}, {27'd0, exp_o});
            chk("codeword", {25'd0, codeword}, {25'd0, m_cw});
        end
    end

    // ---------------- receivers ----------------
    logic [6:0] rx = 7'd0, rx2 = 7'd0, rx5 = 7'd0;
    int n_strobe = 0, n_done = 0, done_cyc = 0;
    int n_strobe2 = 0, n_done2 = 0, n_strobe5 = 0, n_done5 = 0;

    always @(negedge clk) begin
        if (strobe_out) begin
            rx       <= {rx[5:0], d_out};
            n_strobe <= n_strobe + 1;
        end
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc_n;
        end
        if (strobe2) begin
            rx2       <= {rx2[5:0], d_out2};
            n_strobe2 <= n_strobe2 + 1;
        end
        if (done2) n_done2 <= n_done2 + 1;
        if (strobe5) begin
            rx5       <= {rx5[5:0], d_out5};
            n_strobe5 <= n_strobe5 + 1;
        end
        if (done5) n_done5 <= n_done5 + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(input int target, input int bound, input logic glitch);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (glitch && i < FRM - 4) begin
                start = 1'($urandom_range(0, 1));
                d_in  = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            if (n_done >= target) break;
        end
        chk("done_timeout", {31'd0, n_done >= target}, 32'd1);
    endtask

    task automatic send(input logic [3:0] nib, input logic glitch);
        int base;
        base = n_done;
        for (int i = 0; i < 3 * FRM && !ready; i++) @(negedge clk);
        d_in  = nib;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        d_in  = 4'($urandom);
        wait_done(base + 1, FRM + 10, glitch);
    endtask

    task automatic loop_frame(input int which, input logic [3:0] nib);
        int i;
        int base;
        if (which == 2) begin
            base = n_done2; d_in2 = nib; start2 = 1'b1;
        end else begin
            base = n_done5; d_in5 = nib; start5 = 1'b1;
        end
        @(negedge clk);
        #1;
        start2 = (which == 2) ? 1'b0 : start2;
        start5 = (which == 5) ? 1'b0 : start5;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (which == 2 && n_done2 > base) break;
            if (which == 5 && n_done5 > base) break;
        end
        @(negedge clk);
        #1;
        if (which == 2) begin
            chk("loop2_decode", {28'd0, ref_decode(rx2)}, {28'd0, nib});
            chk("loop2_strobes", n_strobe2, 7 * (int'(nib) + 1));
        end else begin
            chk("loop5_decode", {28'd0, ref_decode(rx5)}, {28'd0, nib});
            chk("loop5_strobes", n_strobe5, 7 * (int'(nib) + 1));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s0, d0;
        logic [3:0] nib;
        rst = 1'b1; start = 1'b0; d_in = 4'd0;
        start2 = 1'b0; start5 = 1'b0; d_in2 = 4'd0; d_in5 = 4'd0;
`ifdef ERROR_INJECT_EN
        err_en = 1'b0; err_idx = 3'd7;
`endif
        // Pin the reference model with hand-computed codewords
        chk("model_enc_1011", {25'd0, ref_encode(4'b1011)}, {25'd0, 7'b0110011});
        chk("model_enc_0110", {25'd0, ref_encode(4'b0110)}, {25'd0, 7'b1100110});
        chk("model_dec_flip", {28'd0, ref_decode(7'b0110111)}, {28'd0, 4'b1011});

        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_cw", {25'd0, codeword}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: 1011 -> 0110011, done 28 cycles after the first bit cycle
        s0 = n_strobe;
        send(4'b1011, 1'b0);
        chk("t1_rx", {25'd0, rx}, {25'd0, 7'b0110011});
        chk("t1_strobes", n_strobe - s0, 7);
        chk("t1_done_lat", done_cyc - m_acc, 28);
        chk("t1_cw", {25'd0, codeword}, {25'd0, 7'b0110011});

        // Test 2: all-zero and all-one nibbles
        s0 = n_strobe;
        send(4'b0000, 1'b0);
        chk("t2_rx0", {25'd0, rx}, 32'd0);
        send(4'b1111, 1'b0);
        chk("t2_rx1", {25'd0, rx}, {25'd0, 7'b1111111});
        chk("t2_strobes", n_strobe - s0, 14);

        // Test 3: start held high -> back-to-back frames, no extras
        s0 = n_strobe; d0 = n_done;
        @(negedge clk);
        d_in = 4'b0110; start = 1'b1;
        for (int i = 0; i < 3 * FRM && n_done < d0 + 2; i++) begin
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        chk("t3_two_frames", n_done - d0, 2);
        chk("t3_rx", {25'd0, rx}, {25'd0, 7'b1100110});
        repeat (FRM) @(negedge clk);
        chk("t3_strobes", n_strobe - s0, 14);

        // Test 4: reset after the 3rd strobe drops the frame
        s0 = n_strobe; d0 = n_done;
        d_in = 4'b1001; start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < FRM && n_strobe < s0 + 3; i++) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t4_after_rst", {28'd0, d_out, strobe_out, ready, busy}, {28'd0, 4'b0010});
        rst = 1'b0;
        repeat (2 * FRM) @(negedge clk);
        #1;
        chk("t4_no_strobes", n_strobe - s0, 3);
        chk("t4_no_done", n_done - d0, 0);
        nib = 4'($urandom);
        send(nib, 1'b0);
        chk("t4_fresh", {25'd0, rx}, {25'd0, ref_encode(nib)});

`ifdef ERROR_INJECT_EN
        // Test 5: flip h[2] of the 1011 frame
        err_en = 1'b1; err_idx = 3'd2;
        send(4'b1011, 1'b0);
        err_en = 1'b0; err_idx = 3'd7;
        chk("t5_rx", {25'd0, rx}, {25'd0, 7'b0110111});
        chk("t5_cw", {25'd0, codeword}, {25'd0, 7'b0110011});
        chk("t5_decode", {28'd0, ref_decode(rx)}, {28'd0, 4'b1011});
`endif

        // Random frames with start/d_in noise while busy
        for (int r = 0; r < 24; r++) begin
            nib = 4'($urandom);
            send(nib, 1'b1);
            chk("rand_rx", {25'd0, rx}, {25'd0, m_tx});
            chk("rand_decode", {28'd0, ref_decode(rx)}, {28'd0, nib});
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Test 6: loopback of all nibbles at BIT_CYCLES=2 and 5
        fork
            begin
                for (int n = 0; n < 16; n++) loop_frame(2, 4'(n));
            end
            begin
                for (int m = 0; m < 16; m++) loop_frame(5, 4'(m));
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
